fifo_read_drainer: RTL



---
 rtl/fifo_drain_pkg.sv | 7 +
 rtl/fifo_read_drainer_if.sv | 22 ++
 rtl/fifo_skid_buffer.sv | 39 +++
 rtl/fifo_read_drainer.sv | 64 ++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared states, skid depth and default widths for the FIFO read drainer
package fifo_drain_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;
  localparam int SKID_DEPTH = 3;
  localparam int FIFO_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF = 16;
endpackage

// File: rtl/fifo_read_drainer_if.sv
// fifo_read_drainer_if: FIFO read port plus downstream valid/ready stream
interface fifo_read_drainer_if
  import fifo_drain_pkg::*;
#(
  parameter int W = FIFO_WIDTH_DEF
);
  logic fifo_empty;
  logic fifo_underflow;
  logic [W-1:0] fifo_dout;
  logic fifo_rd_en;
  logic m_valid;
  logic [W-1:0] m_data;
  logic m_ready;
  modport master (
    input fifo_empty, fifo_underflow, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data
  );
  modport slave (
    output fifo_empty, fifo_underflow, fifo_dout, m_ready,
    input fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_skid_buffer.sv
// fifo_skid_buffer: small register FIFO with push/pop/count; pop on empty is ignored
module fifo_skid_buffer
  import fifo_drain_pkg::*;
#(
  parameter int W = FIFO_WIDTH_DEF,
  parameter int DEPTH = SKID_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign do_pop = pop && (count != '0);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      if (push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fifo_read_drainer.sv
// fifo_read_drainer: issues FIFO reads, absorbs the registered read latency and
// re-presents words on a valid/ready stream without a ready-to-rd_en path
module fifo_read_drainer
  import fifo_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  fifo_read_drainer_if.master bus,
  output logic busy,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic err_underflow
);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  state_t state, state_nx;
  logic pending;
  logic rd_en;
  logic valid;
  logic pop;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic [FIFO_WIDTH-1:0] data;
  fifo_skid_buffer #(.W(FIFO_WIDTH), .DEPTH(SKID_DEPTH)) u_skid (
    .clk(clk),
    .rst(rst),
    .push(pending),
    .din(bus.fifo_dout),
    .pop(pop),
    .dout(data),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pending <= 1'b0;
      rd_count <= '0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_nx;
      pending <= rd_en;
      rd_count <= rd_count + CNT_WIDTH'(pop);
      err_underflow <= err_underflow | bus.fifo_underflow;
    end
  end
  // occupancy counts the word already in flight so the buffer can never overflow
  always_comb begin
    occ = {1'b0, count} + (CW + 1)'(pending);
    valid = count != '0;
    pop = valid && bus.m_ready;
    rd_en = (state == ACTIVE) && !bus.fifo_empty && (occ < (CW + 1)'(SKID_DEPTH));
    busy = state != IDLE;
    state_nx = (state == IDLE)   ? (enable ? ACTIVE : IDLE) :
               (state == ACTIVE) ? (enable ? ACTIVE : DRAIN) :
               (state == DRAIN)  ? (enable ? ACTIVE : ((!pending && count == '0) ? IDLE : DRAIN)) :
                                   IDLE;
  end
  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid = valid;
  assign bus.m_data = data;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) occ <= (CW + 1)'(SKID_DEPTH));
endmodule
